// File: rtl/ram_sdp_pkg.sv
// ram_sdp_pkg - definitions shared by the simple-dual-port RAM and its clear
// controller.
//   - RL_ONE / RL_TWO : the legal read latencies
//   - clr_state_t     : clear-engine state encodings (S_IDLE, S_CLEAR)
//   - legal_latency() : helper for the elaboration-time configuration check
// The file is guarded so that it may be pulled into a compile more than once.
`ifndef RAM_SDP_PKG_SV
`define RAM_SDP_PKG_SV

package ram_sdp_pkg;

    localparam int RL_ONE = 1;
    localparam int RL_TWO = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;

    function automatic bit legal_latency(input int rl);
        return (rl == RL_ONE) || (rl == RL_TWO);
    endfunction

endpackage

`endif

// File: rtl/ram_clear_ctl.sv
// ram_clear_ctl - post-reset clear engine for ram_sdp.
// Sweeps every address once after reset, asserting a write-enable for a zero
// word at each address, then idles until the next reset.
// Ports:
//   clk      in   clock
//   srst     in   synchronous active-high reset; forces CLEAR, counter = 0
//   busy     out  high while the sweep is in progress
//   clr_we   out  clear write enable
//   clr_addr out  clear write address
module ram_clear_ctl
    import ram_sdp_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= S_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_we     = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                clr_we   = 1'b1;
                // Counter is exactly ADDR_WIDTH wide, so it wraps back to 0
                // on the same edge that leaves CLEAR.
                cnt_next = cnt_reg + ADDR_WIDTH'(1);
                if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy     = (state_reg == S_CLEAR);
    assign clr_addr = cnt_reg;

endmodule

// File: rtl/ram_sdp.sv
// ram_sdp - simple-dual-port RAM: one masked write port, one read port, one
// clock. Same-address read/write collisions are write-first per lane. Read
// data is registered with a latency of 1 or 2 cycles and qualified by
// or_valid.
// Optional feature: define RAM_CLEAR_EN to include the post-reset clear
// engine (ram_clear_ctl); without it o_busy is tied low and the array is
// not initialised.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_we/i_waddr/i_wdata/i_wmask   write request, address, data, lane mask
//   i_re/i_raddr        read request, address
//   or_data/or_valid    registered read result and its one-cycle strobe
//   o_busy              clear engine active; requests are dropped
module ram_sdp
    import ram_sdp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_we,
    input  logic [ADDR_WIDTH-1:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] i_wmask,
    input  logic                             i_re,
    input  logic [ADDR_WIDTH-1:0]            i_raddr,
    output logic [DATA_WIDTH-1:0]            or_data,
    output logic                             or_valid,
    output logic                             o_busy
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % LANE_WIDTH) != 0 || !legal_latency(READ_LATENCY)) begin : g_bad_cfg
            $error("ram_sdp: DATA_WIDTH must be a multiple of LANE_WIDTH and READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
    ram_clear_ctl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_ctl (
        .clk     (i_clk),
        .srst    (i_rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign o_busy = busy;

    // User requests are only honoured outside reset and outside the sweep.
    logic user_we;
    logic user_re;
    assign user_we = i_we & ~busy & ~i_rst;
    assign user_re = i_re & ~busy & ~i_rst;

    // The clear engine owns the write port while busy.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_mask;
    assign wr_en   = busy ? clr_we            : user_we;
    assign wr_addr = busy ? clr_addr          : i_waddr;
    assign wr_data = busy ? '0                : i_wdata;
    assign wr_mask = busy ? {LANES{1'b1}}     : i_wmask;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_mask[k]) begin
                    mem[wr_addr][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Write-first bypass: lanes being written this cycle at the read address
    // return the new data, the rest return the stored word.
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    assign rd_hit = user_we && (i_waddr == i_raddr);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign rd_word[gi*LANE_WIDTH +: LANE_WIDTH] =
                (rd_hit && i_wmask[gi]) ? i_wdata[gi*LANE_WIDTH +: LANE_WIDTH]
                                        : mem[i_raddr][gi*LANE_WIDTH +: LANE_WIDTH];
        end
    endgenerate

    generate
        if (READ_LATENCY == RL_TWO) begin : g_rl2
            logic [DATA_WIDTH-1:0] s1_data_reg;
            logic                  s1_valid_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s1_data_reg  <= '0;
                    s1_valid_reg <= 1'b0;
                    or_data      <= '0;
                    or_valid     <= 1'b0;
                end else begin
                    s1_valid_reg <= user_re;
                    if (user_re) begin
                        s1_data_reg <= rd_word;
                    end
                    or_valid <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        or_data <= s1_data_reg;
                    end
                end
            end
        end else begin : g_rl1
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    or_data  <= '0;
                    or_valid <= 1'b0;
                end else begin
                    or_valid <= user_re;
                    if (user_re) begin
                        or_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp - scoreboard bench for ram_sdp. Two instances (read latency 1
// and 2) share one stimulus stream; each has its own expected-result queue
// and monitor. Expected data come from a plain array model of the memory.
module tb_ram_sdp;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int NL = DW / LW;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_we = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic [NL-1:0] i_wmask = '0;
    logic          i_re = 1'b0;
    logic [AW-1:0] i_raddr = '0;

    logic [DW-1:0] d1, d2;
    logic          v1, v2, b1, b2;

    always #5 clk = ~clk;

    ram_sdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .READ_LATENCY(1)) u_rl1 (
        .i_clk(clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_re(i_re), .i_raddr(i_raddr),
        .or_data(d1), .or_valid(v1), .o_busy(b1)
    );

    ram_sdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .READ_LATENCY(2)) u_rl2 (
        .i_clk(clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_re(i_re), .i_raddr(i_raddr),
        .or_data(d2), .or_valid(v2), .o_busy(b2)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] model [DEPTH];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: every or_valid pulse must match the head of its queue, both
    // in data and in the cycle it was due.
    always @(negedge clk) begin
        if (v1 === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rl1_spurious: or_valid with data %h at cycle %0d, required no result", d1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (d1 !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rl1_read: data %h at cycle %0d, required %h at cycle %0d", d1, cyc, e.data, e.due);
                end else begin
                    $display("rl1 read  data %h cycle %0d ok", d1, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (v2 === 1'b1) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL rl2_spurious: or_valid with data %h at cycle %0d, required no result", d2, cyc);
            end else begin
                exp_t e;
                e = q2.pop_front();
                if (d2 !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rl2_read: data %h at cycle %0d, required %h at cycle %0d", d2, cyc, e.data, e.due);
                end else begin
                    $display("rl2 read  data %h cycle %0d ok", d2, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // Apply one cycle of requests at a negedge; the model applies the write
    // before the read, which gives write-first behaviour per lane.
    task automatic apply_model(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [NL-1:0] wm, input bit re, input logic [AW-1:0] ra);
        if (we) begin
            for (int k = 0; k < NL; k++) begin
                if (wm[k]) model[wa][k*LW +: LW] = wd[k*LW +: LW];
            end
        end
        if (re) begin
            q1.push_back('{data: model[ra], due: cyc + 1});
            q2.push_back('{data: model[ra], due: cyc + 2});
        end
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NL-1:0] wm, input bit re, input logic [AW-1:0] ra);
        i_we = we; i_waddr = wa; i_wdata = wd; i_wmask = wm;
        i_re = re; i_raddr = ra;
        apply_model(we, wa, wd, wm, re, ra);
        @(negedge clk);
        i_we = 1'b0;
        i_re = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rl1_valid"}, 32'(v1), 32'd0);
        chk({tag, "_rl1_data"},  32'(d1), 32'd0);
        chk({tag, "_rl2_valid"}, 32'(v2), 32'd0);
        chk({tag, "_rl2_data"},  32'(d2), 32'd0);
        chk({tag, "_busy"},      32'(b1), 32'(CLR));
    endtask

    // Called at the negedge on which reset was released. Optionally issues a
    // read+write to address 9 in that first cycle (dropped when clearing).
    task automatic measure_busy(input bit with_drop);
        int c1 = 0;
        int c2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (b1 === 1'b1) c1++;
            if (b2 === 1'b1) c2++;
            if (with_drop && i == 0) begin
                i_we = 1'b1; i_waddr = 4'd9; i_wdata = 16'hFFFF; i_wmask = 2'b11;
                i_re = 1'b1; i_raddr = 4'd9;
                if (!CLR) apply_model(1'b1, 4'd9, 16'hFFFF, 2'b11, 1'b1, 4'd9);
            end else begin
                i_we = 1'b0;
                i_re = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy_len_rl1", 32'(c1), CLR ? 32'(DEPTH) : 32'd0);
        chk("busy_len_rl2", 32'(c2), CLR ? 32'(DEPTH) : 32'd0);
        if (CLR) begin
            for (int a = 0; a < DEPTH; a++) model[a] = '0;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) issue(1'b0, '0, '0, '0, 1'b1, AW'(a));
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, DEPTH - 1));
            issue(1'($urandom_range(0, 1)), wa, DW'($urandom), NL'($urandom),
                  1'($urandom_range(0, 1)), ra);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release reset; a request in the first busy cycle must be dropped.
        i_rst = 1'b0;
        measure_busy(1'b1);

        if (!CLR) begin
            for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), DW'($urandom), 2'b11, 1'b0, '0);
        end

        // Back-to-back reads of every address (zeros after a clear).
        read_all();

        // Masked writes: expect 0xAB34 at address 3.
        issue(1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, '0);
        issue(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, '0);
        issue(1'b0, '0, '0, '0, 1'b1, 4'd3);

        // Collision: mem[5]=0x00FF, write 0x1200 mask 10 while reading 5.
        issue(1'b1, 4'd5, 16'h00FF, 2'b11, 1'b0, '0);
        issue(1'b1, 4'd5, 16'h1200, 2'b10, 1'b1, 4'd5);

        // All-zero mask is a no-op.
        issue(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b1, 4'd5);

        random_traffic(300);
        repeat (4) @(negedge clk);

        // Reset with reads in flight: results still in the pipe are lost.
        issue(1'b0, '0, '0, '0, 1'b1, 4'd1);
        issue(1'b0, '0, '0, '0, 1'b1, 4'd2);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        q1.delete();
        q2.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("midop_reset");
        i_rst = 1'b0;
        measure_busy(1'b0);

        if (CLR) begin
            // Reset in the middle of the sweep restarts it from address 0.
            random_traffic(20);
            i_rst = 1'b1;
            repeat (2) @(negedge clk);
            i_rst = 1'b0;
            repeat (8) @(negedge clk);
            i_rst = 1'b1;
            repeat (2) @(negedge clk);
            i_rst = 1'b0;
            measure_busy(1'b0);
        end

        read_all();
        random_traffic(100);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("rl1_queue_drained", 32'(q1.size()), 32'd0);
        chk("rl2_queue_drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
